cond_logic: RTL and testbench

- Conditional-execution stage directly downstream of the single-cycle instruction decoder.
- Holds the architectural NZCV flag register and evaluates the instruction's 4-bit condition field against the stored flags.
- Gates the decoder's raw write/branch requests (PCS, RegW, MemW) into the final PCSrc/RegWrite/MemWrite strobes used by the datapath.
- Updates flags from the ALU under FlagW control and keeps saturating executed/annulled instruction counters for debug and performance.

---
 rtl/cond_pkg.sv | 26 ++
 rtl/cond_check.sv | 41 ++++
 rtl/cond_logic.sv | 95 +++++++++
 tb/tb_cond_logic.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared condition codes and flag bit positions for the conditional-execution stage.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int unsigned N_IDX = 3;
    localparam int unsigned Z_IDX = 2;
    localparam int unsigned C_IDX = 1;
    localparam int unsigned V_IDX = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of a 4-bit condition field against {N,Z,C,V}.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[N_IDX];
    assign z = flags[Z_IDX];
    assign c = flags[C_IDX];
    assign v = flags[V_IDX];

    // Condition table; the reserved code annuls the instruction
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = ~(n ^ v);
            COND_LT: cond_ex = n ^ v;
            COND_GT: cond_ex = ~z & ~(n ^ v);
            COND_LE: cond_ex = z | (n ^ v);
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: NZCV register, strobe gating and saturating
// executed/annulled counters.
module cond_logic
    import cond_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             CntClr,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] ExecCnt,
    output logic [CNT_W-1:0] SkipCnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [3:0]       flags_q;
    logic [3:0]       flags_d;
    logic [CNT_W-1:0] exec_q;
    logic [CNT_W-1:0] skip_q;
    logic             cond_ex;

    cond_check u_cond_check (
        .cond    (Cond),
        .flags   (flags_q),
        .cond_ex (cond_ex)
    );

    assign CondEx  = cond_ex;
    assign Flags   = flags_q;
    assign ExecCnt = exec_q;
    assign SkipCnt = skip_q;

    // Gate decoder strobes by the condition; nothing leaves the stage during reset
    always_comb begin
        PCSrc    = 1'b0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        if (!reset) begin
            PCSrc    = PCS  & cond_ex;
            RegWrite = RegW & cond_ex;
            MemWrite = MemW & cond_ex;
        end
    end

    // Next flags: N,Z and C,V halves are written independently
    always_comb begin
        flags_d = flags_q;
        if (cond_ex && FlagW[1]) begin
            flags_d[N_IDX] = ALUFlags[N_IDX];
            flags_d[Z_IDX] = ALUFlags[Z_IDX];
        end
        if (cond_ex && FlagW[0]) begin
            flags_d[C_IDX] = ALUFlags[C_IDX];
            flags_d[V_IDX] = ALUFlags[V_IDX];
        end
    end

    // Flag register
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    // Saturating performance counters; clear beats increment
    always_ff @(posedge clk) begin
        if (reset || CntClr) begin
            exec_q <= '0;
            skip_q <= '0;
        end else if (cond_ex) begin
            if (exec_q != CNT_MAX) begin
                exec_q <= exec_q + CNT_W'(1);
            end
        end else begin
            if (skip_q != CNT_MAX) begin
                skip_q <= skip_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: reference model plus directed literal checks.
module tb_cond_logic;

    localparam int unsigned CNT_W = 4;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS;
    logic             RegW;
    logic             MemW;
    logic             CntClr;
    logic             PCSrc;
    logic             RegWrite;
    logic             MemWrite;
    logic             CondEx;
    logic [3:0]       Flags;
    logic [CNT_W-1:0] ExecCnt;
    logic [CNT_W-1:0] SkipCnt;

    int n_cmp;
    int n_err;

    // model state
    logic [3:0] m_flags;
    int         m_exec;
    int         m_skip;

    cond_logic #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .RegW     (RegW),
        .MemW     (MemW),
        .CntClr   (CntClr),
        .PCSrc    (PCSrc),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .CondEx   (CondEx),
        .Flags    (Flags),
        .ExecCnt  (ExecCnt),
        .SkipCnt  (SkipCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pairs of codes test a base predicate and its inverse; 1110 always, 1111 never
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !base : base;
    endfunction

    // Reference model advances on each rising edge
    always @(posedge clk) begin
        logic ce;
        ce = cond_pass(Cond, m_flags);
        if (reset) begin
            m_flags <= 4'b0000;
            m_exec  <= 0;
            m_skip  <= 0;
        end else begin
            if (ce && FlagW[1]) m_flags[3:2] <= ALUFlags[3:2];
            if (ce && FlagW[0]) m_flags[1:0] <= ALUFlags[1:0];
            if (CntClr) begin
                m_exec <= 0;
                m_skip <= 0;
            end else if (ce) begin
                m_exec <= (m_exec < CNT_SAT) ? m_exec + 1 : m_exec;
            end else begin
                m_skip <= (m_skip < CNT_SAT) ? m_skip + 1 : m_skip;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model
    task automatic compare_model();
        logic ce;
        ce = cond_pass(Cond, m_flags);
        chk("model_flags",    32'(Flags),    32'(m_flags));
        chk("model_condex",   32'(CondEx),   32'(ce));
        chk("model_pcsrc",    32'(PCSrc),    32'(!reset && PCS && ce));
        chk("model_regwrite", 32'(RegWrite), 32'(!reset && RegW && ce));
        chk("model_memwrite", 32'(MemWrite), 32'(!reset && MemW && ce));
        chk("model_execcnt",  32'(ExecCnt),  32'(m_exec));
        chk("model_skipcnt",  32'(SkipCnt),  32'(m_skip));
    endtask

    // Apply one cycle of inputs at the falling edge, then check mid-cycle
    task automatic drive(input logic rst, input logic [3:0] c, input logic [3:0] alu,
                         input logic [1:0] fw, input logic pcs, input logic regw,
                         input logic memw, input logic clr);
        @(negedge clk);
        reset = rst; Cond = c; ALUFlags = alu; FlagW = fw;
        PCS = pcs; RegW = regw; MemW = memw; CntClr = clr;
        #2;
        compare_model();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1; Cond = 4'hE; ALUFlags = 4'hF; FlagW = 2'b11;
        PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; CntClr = 1'b0;

        // reset with an executing instruction pending
        drive(1'b1, 4'hE, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("rst_pcsrc", 32'(PCSrc), 32'd0);
        chk("rst_regwrite", 32'(RegWrite), 32'd0);

        // first AL instruction
        drive(1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("al_flags", 32'(Flags), 32'h0);
        chk("al_condex", 32'(CondEx), 32'd1);
        chk("al_regwrite", 32'(RegWrite), 32'd1);
        chk("al_memwrite", 32'(MemWrite), 32'd1);
        chk("al_exec0", 32'(ExecCnt), 32'd0);

        // EQ fails on zero flags
        drive(1'b0, 4'h0, 4'h4, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("al_exec1", 32'(ExecCnt), 32'd1);
        chk("al_skip0", 32'(SkipCnt), 32'd0);
        chk("eq_condex0", 32'(CondEx), 32'd0);
        chk("eq_regwrite0", 32'(RegWrite), 32'd0);
        drive(1'b0, 4'hE, 4'h4, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("eq_noflag", 32'(Flags), 32'h0);
        chk("eq_skip1", 32'(SkipCnt), 32'd1);
        drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("al_setz", 32'(Flags), 32'h4);
        chk("eq_condex1", 32'(CondEx), 32'd1);

        // partial flag writes
        drive(1'b0, 4'hE, 4'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'hE, 4'hF, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("clear_flags", 32'(Flags), 32'h0);
        drive(1'b0, 4'hE, 4'h1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("nz_write", 32'(Flags), 32'hC);
        drive(1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("cv_write", 32'(Flags), 32'hD);

        // sweep every condition against every flag state
        for (int f = 0; f < 16; f++) begin
            drive(1'b0, 4'hE, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
            for (int c = 0; c < 16; c++) begin
                drive(1'b0, 4'(c), 4'(~f), 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
                if (f == 9 && c == 10) chk("f9_ge", 32'(CondEx), 32'd1);
                if (f == 9 && c == 11) chk("f9_lt", 32'(CondEx), 32'd0);
                if (f == 9 && c == 12) chk("f9_gt", 32'(CondEx), 32'd1);
                if (f == 9 && c == 13) chk("f9_le", 32'(CondEx), 32'd0);
                if (f == 6 && c == 8)  chk("f6_hi", 32'(CondEx), 32'd0);
                if (f == 6 && c == 9)  chk("f6_ls", 32'(CondEx), 32'd1);
                if (c == 15) chk("nv_pcsrc", 32'(PCSrc), 32'd0);
            end
        end

        // counter clear, saturation, clear priority over increment
        drive(1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("clr_exec", 32'(ExecCnt), 32'd0);
        chk("clr_skip", 32'(SkipCnt), 32'd0);
        for (int i = 0; i < 19; i++) drive(1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sat_exec", 32'(ExecCnt), 32'd15);
        drive(1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("sat_hold", 32'(ExecCnt), 32'd15);
        drive(1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("clr_prio", 32'(ExecCnt), 32'd0);

        // reset mid-operation discards the flag write
        drive(1'b0, 4'hE, 4'h6, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'hE, 4'hF, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_pcsrc", 32'(PCSrc), 32'd0);
        chk("pre_rst_flags", 32'(Flags), 32'h6);
        drive(1'b0, 4'hF, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_flags", 32'(Flags), 32'h0);
        chk("mid_rst_exec", 32'(ExecCnt), 32'd0);
        chk("mid_rst_skip", 32'(SkipCnt), 32'd0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 39) == 0),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 23) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
